// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, RV32I funct3 codes
// and the sign/size mask handed to the data memory.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_LOAD_CAP = 2'd2,
    ST_RESP     = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // bit3 = sign-extend, bits[2:0] = byte lanes touched (thermometer)
  localparam logic [3:0] MASK_LB  = 4'b1001;
  localparam logic [3:0] MASK_LH  = 4'b1011;
  localparam logic [3:0] MASK_LW  = 4'b1111;
  localparam logic [3:0] MASK_LBU = 4'b0001;
  localparam logic [3:0] MASK_LHU = 4'b0011;
  localparam logic [3:0] MASK_SB  = 4'b0001;
  localparam logic [3:0] MASK_SH  = 4'b0011;
  localparam logic [3:0] MASK_SW  = 4'b0111;

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational request decode: effective address, memory mask, and the
// misalignment / fault classification used to pick the error path.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_4000,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter logic [31:0] LED_ADDR   = 32'h0000_2000
) (
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] base_i,
  input  logic [31:0] offset_i,
  output logic [31:0] ea_o,
  output logic [3:0]  mask_o,
  output logic        misaligned_o,
  output logic        fault_o
);

  localparam logic [32:0] DMEM_LO = {1'b0, DMEM_BASE};
  localparam logic [32:0] DMEM_HI = DMEM_LO + 33'(4 * DMEM_WORDS);

  logic legal;
  logic in_range;
  logic is_led;

  always_comb begin
    ea_o   = base_i + offset_i;
    mask_o = 4'b0000;
    legal  = 1'b0;
    if (load_i && !store_i) begin
      legal = 1'b1;
      case (funct3_i)
        F3_LB:   mask_o = MASK_LB;
        F3_LH:   mask_o = MASK_LH;
        F3_LW:   mask_o = MASK_LW;
        F3_LBU:  mask_o = MASK_LBU;
        F3_LHU:  mask_o = MASK_LHU;
        default: legal  = 1'b0;
      endcase
    end else if (store_i && !load_i) begin
      legal = 1'b1;
      case (funct3_i)
        F3_SB:   mask_o = MASK_SB;
        F3_SH:   mask_o = MASK_SH;
        F3_SW:   mask_o = MASK_SW;
        default: legal  = 1'b0;
      endcase
    end

    // A word access also needs ea[0] clear, so the half test covers it too.
    misaligned_o = legal && ((mask_o[2] && (ea_o[1:0] != 2'b00)) ||
                             (mask_o[1] && ea_o[0]));

    in_range = ({1'b0, ea_o} >= DMEM_LO) && ({1'b0, ea_o} < DMEM_HI);
    is_led   = (ea_o == LED_ADDR);
    fault_o  = !legal || (!in_range && !is_led) || (load_i && is_led);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes a pipeline request, drives one
// memory strobe (holding it through stalls) and returns a one-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_4000,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter logic [31:0] LED_ADDR   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is taken on any rising edge where req_valid and
  // req_ready are both high; req_ready is high only while idle. Responses
  // are a single-cycle resp_valid pulse with no backpressure.

  lsu_state_e  state_q;
  logic [4:0]  rd_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        memread_q;
  logic        memwrite_q;
  logic [3:0]  mask_q;
  logic        resp_valid_q;
  logic [4:0]  resp_rd_q;
  logic [31:0] resp_data_q;
  logic        resp_mis_q;
  logic        resp_fault_q;

  logic [31:0] ea;
  logic [3:0]  mask;
  logic        misaligned;
  logic        fault;

  lsu_addr_check #(
    .DMEM_BASE (DMEM_BASE),
    .DMEM_WORDS(DMEM_WORDS),
    .LED_ADDR  (LED_ADDR)
  ) u_addr_check (
    .load_i      (req_load),
    .store_i     (req_store),
    .funct3_i    (req_funct3),
    .base_i      (req_base),
    .offset_i    (req_offset),
    .ea_o        (ea),
    .mask_o      (mask),
    .misaligned_o(misaligned),
    .fault_o     (fault)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_q         <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      mask_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      resp_mis_q   <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      resp_mis_q   <= 1'b0;
      resp_fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            rd_q <= req_rd;
            if (misaligned || fault) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rd_q    <= req_rd;
              resp_mis_q   <= misaligned;
              resp_fault_q <= fault;
            end else begin
              state_q     <= ST_ISSUE;
              mem_addr_q  <= ea;
              mem_wdata_q <= req_store ? req_wdata : 32'h0;
              memread_q   <= req_load;
              memwrite_q  <= req_store;
              mask_q      <= mask;
            end
          end
        end
        ST_ISSUE: begin
          if (!mem_clk_stall) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            mask_q      <= '0;
            if (memread_q) begin
              state_q <= ST_LOAD_CAP;
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rd_q    <= rd_q;
            end
          end
        end
        ST_LOAD_CAP: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_rd_q    <= rd_q;
          resp_data_q  <= mem_read_data;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready       = (state_q == ST_IDLE);
  assign mem_addr        = mem_addr_q;
  assign mem_write_data  = mem_wdata_q;
  assign mem_memread     = memread_q;
  assign mem_memwrite    = memwrite_q;
  assign mem_sign_mask   = mask_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rd         = resp_rd_q;
  assign resp_data       = resp_data_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_fault      = resp_fault_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, a mid-issue reset
// and randomized requests checked cycle by cycle against a rule-level model.
module tb_load_store_unit;

  localparam logic [31:0] DMEM_BASE  = 32'h0000_4000;
  localparam int unsigned DMEM_WORDS = 1024;
  localparam logic [31:0] LED_ADDR   = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memread, mem_memwrite, mem_clk_stall;
  logic [3:0]  mem_sign_mask;
  logic        resp_valid, resp_misaligned, resp_fault;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  load_store_unit #(
    .DMEM_BASE(DMEM_BASE), .DMEM_WORDS(DMEM_WORDS), .LED_ADDR(LED_ADDR)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    req_load   = 1'($urandom);
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_base   = $urandom;
    req_offset = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd_strobe"}, {31'h0, mem_memread}, 32'h0);
    check({tag, "_wr_strobe"}, {31'h0, mem_memwrite}, 32'h0);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_mask"}, {28'h0, mem_sign_mask}, 32'h0);
  endtask

  task automatic check_resp(input logic [4:0] rd, input logic mis, input logic flt);
    logic [31:0] exp_data;
    exp_data = exp_q.pop_front();
    check("resp_valid", {31'h0, resp_valid}, 32'h1);
    check("resp_rd", {27'h0, resp_rd}, {27'h0, rd});
    check("resp_data", resp_data, exp_data);
    check("resp_misaligned", {31'h0, resp_misaligned}, {31'h0, mis});
    check("resp_fault", {31'h0, resp_fault}, {31'h0, flt});
  endtask

  // driver + model: one request through its full lifetime, starting #1 after a posedge
  task automatic run_req(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int stall_n, input logic [31:0] rdata);
    logic [31:0] ea;
    int          bytes;
    logic        sgn, legal, mis, flt, led, in_dmem;
    logic [3:0]  exp_mask;
    int          k;

    ea    = base + off;
    legal = 1'b0;
    bytes = 1;
    sgn   = 1'b0;
    if (ld && !st && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      legal = 1'b1;
      bytes = 1 << f3[1:0];
      sgn   = !f3[2];
    end else if (st && !ld && f3 <= 3'd2) begin
      legal = 1'b1;
      bytes = 1 << f3[1:0];
    end
    mis      = legal && ((ea % bytes) != 0);
    led      = (ea == LED_ADDR);
    in_dmem  = (ea >= DMEM_BASE) && (longint'(ea - DMEM_BASE) < 4 * longint'(DMEM_WORDS));
    flt      = !legal || (!in_dmem && !led) || (ld && led);
    exp_mask = {sgn, 3'((1 << bytes) - 1)};
    exp_q.push_back((ld && !mis && !flt) ? rdata : 32'h0);

    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready", {31'h0, req_ready}, 32'h1);

    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wdata; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble_inputs();

    if (mis || flt) begin
      @(negedge clk);
      check_quiet("err");
      check_resp(rd, mis, flt);
    end else begin
      for (int i = 0; i <= stall_n; i++) begin
        mem_clk_stall = (i < stall_n);
        @(negedge clk);
        check("issue_rd_strobe", {31'h0, mem_memread}, {31'h0, ld});
        check("issue_wr_strobe", {31'h0, mem_memwrite}, {31'h0, st});
        check("issue_addr", mem_addr, ea);
        check("issue_mask", {28'h0, mem_sign_mask}, {28'h0, exp_mask});
        if (st) check("issue_wdata", mem_write_data, wdata);
        check("issue_no_resp", {31'h0, resp_valid}, 32'h0);
        check("issue_not_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
      end
      mem_clk_stall = 1'b0;
      if (ld) begin
        mem_read_data = rdata;
        @(negedge clk);
        check_quiet("cap");
        check("cap_no_resp", {31'h0, resp_valid}, 32'h0);
        @(posedge clk); #1;
        mem_read_data = $urandom;
      end
      @(negedge clk);
      check_quiet("resp");
      check_resp(rd, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
    check("back_to_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; mem_clk_stall = 1'b0; mem_read_data = '0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'h0, req_ready}, 32'h1);
    check("reset_resp", {31'h0, resp_valid}, 32'h0);
    check_quiet("reset");
    @(posedge clk); #1;

    // directed cases
    run_req(1, 0, 3'b010, 32'h4000, 32'd8, 32'h0, 5'd3, 0, 32'hDEADBEEF);
    run_req(0, 1, 3'b000, 32'h4003, 32'd0, 32'h0000_00A5, 5'd7, 0, 32'h0);
    run_req(1, 0, 3'b001, 32'h4001, 32'd0, 32'h0, 5'd9, 0, 32'h0);
    run_req(0, 1, 3'b010, 32'h2000, 32'd0, 32'h1234_5678, 5'd1, 0, 32'h0);
    run_req(1, 0, 3'b010, 32'h5000, 32'd0, 32'h0, 5'd2, 0, 32'h0);
    run_req(1, 0, 3'b011, 32'h4000, 32'd0, 32'h0, 5'd4, 0, 32'h0);
    run_req(1, 0, 3'b010, 32'h4100, 32'd4, 32'h0, 5'd5, 3, 32'hCAFE_F00D);
    run_req(1, 0, 3'b100, 32'h5000, 32'hFFFF_FFFF, 32'h0, 5'd6, 0, 32'h0000_0080);
    run_req(1, 0, 3'b010, 32'h3FFC, 32'd0, 32'h0, 5'd8, 0, 32'h0);
    run_req(1, 0, 3'b010, LED_ADDR, 32'd0, 32'h0, 5'd10, 0, 32'h0);
    run_req(1, 1, 3'b010, 32'h4000, 32'd0, 32'h0, 5'd11, 0, 32'h0);
    run_req(0, 0, 3'b000, 32'h4000, 32'd0, 32'h0, 5'd12, 0, 32'h0);
    run_req(0, 1, 3'b011, 32'h4000, 32'd0, 32'h0, 5'd13, 0, 32'h0);
    run_req(0, 1, 3'b001, 32'h4006, 32'd0, 32'hBEEF_0001, 5'd14, 2, 32'h0);

    // reset asserted mid-issue
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_base = 32'h4000; req_offset = 32'd0; req_rd = 5'd15;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_clk_stall = 1'b1;
    @(negedge clk);
    check("pre_reset_rd_strobe", {31'h0, mem_memread}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check_quiet("async_reset");
    check("async_reset_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet("held_reset");
    reset = 1'b0;
    mem_clk_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_ready", {31'h0, req_ready}, 32'h1);
      check("post_reset_no_resp", {31'h0, resp_valid}, 32'h0);
      check("post_reset_no_strobe", {30'h0, mem_memread, mem_memwrite}, 32'h0);
    end
    @(posedge clk); #1;

    // randomized requests
    for (int n = 0; n < 300; n++) begin
      logic ld, st;
      logic [31:0] base, off;
      int sel;
      sel = $urandom_range(0, 9);
      ld  = (sel < 5) || (sel == 9 && $urandom_range(0, 1) == 1);
      st  = (sel >= 5 && sel < 9) || (sel == 9 && ld);
      case ($urandom_range(0, 3))
        0:       begin base = DMEM_BASE + $urandom_range(0, 4095); off = $urandom_range(0, 32) - 16; end
        1:       begin base = LED_ADDR; off = $urandom_range(0, 3) == 0 ? $urandom_range(0, 4) : 32'h0; end
        2:       begin base = $urandom; off = $urandom; end
        default: begin base = DMEM_BASE + 4 * DMEM_WORDS - 8; off = $urandom_range(0, 12); end
      endcase
      run_req(ld, st, 3'($urandom_range(0, 7)), base, off, $urandom,
              5'($urandom), $urandom_range(0, 3), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
